// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: architectural sizes and the register-file
// clear/run state encoding.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on writeback, with per-read-port lookups that see the same-cycle writeback.
module reg_file_scoreboard #(
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: a newer issue to the same register outranks its writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (set_en && (set_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Busy bit register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            busy_q <= {DEPTH{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        logic [ADDR_W-1:0] ra_s;
        assign ra_s       = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_busy[k] = busy_q[ra_s] & ~(clr_en & (clr_addr == ra_s));
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file for the ID stage: write->read bypass,
// optional hardwired-zero entry 0, post-reset clear sweep and pending-write scoreboard.
module reg_file_mp
    import rv_pkg::*;
#(
    parameter int  DATA_W    = XLEN,
    parameter int  DEPTH     = REG_COUNT,
    parameter int  NUM_RD    = 2,
    parameter int  ZERO_REG0 = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        IN,
    input  logic [ADDR_W-1:0]        INADDRESS,
    input  logic                     WRITE,
    input  logic                     ISSUE_EN,
    input  logic [ADDR_W-1:0]        ISSUE_ADDR,
    input  logic [NUM_RD*ADDR_W-1:0] OUT_ADDR,
    output logic [NUM_RD*DATA_W-1:0] OUT_DATA,
    output logic [NUM_RD-1:0]        OUT_BUSY,
    output logic                     READY
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic              HAS_ZERO = (ZERO_REG0 != 0);

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;
    logic              ready_q;
    logic              ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run_s;
    logic              wr_en_s;
    logic              issue_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_wa_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic [NUM_RD-1:0] sb_busy_s;

    // Writes and issues only take effect in RUN; entry 0 may be hardwired.
    assign run_s      = (state_q == RF_RUN);
    assign wr_en_s    = run_s & WRITE & ~(HAS_ZERO & (INADDRESS == ZERO_IDX));
    assign issue_en_s = run_s & ISSUE_EN & ~(HAS_ZERO & (ISSUE_ADDR == ZERO_IDX));
    assign READY      = ready_q;

    // Clear-sweep FSM: walk every entry once, then run.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        case (state_q)
            RF_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1'b1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = RF_CLEAR;
                    ready_d = 1'b0;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_ptr_d = ZERO_IDX;
                ready_d   = 1'b0;
            end
        endcase
    end

    // FSM state, sweep pointer and READY register; reset restarts the sweep.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= ZERO_IDX;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
        end
    end

    // Single storage write port shared by the sweep and writeback.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = ZERO_IDX;
        mem_wd_s = {DATA_W{1'b0}};
        if (state_q == RF_CLEAR) begin
            mem_we_s = 1'b1;
            mem_wa_s = clr_ptr_q;
            mem_wd_s = {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = INADDRESS;
            mem_wd_s = IN;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Register storage.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    reg_file_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (CLK),
        .clr      (RESET),
        .set_en   (issue_en_s),
        .set_addr (ISSUE_ADDR),
        .clr_en   (wr_en_s),
        .clr_addr (INADDRESS),
        .rd_addr  (OUT_ADDR),
        .rd_busy  (sb_busy_s)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              zero_hit_s;
        logic [DATA_W-1:0] rd_data_s;

        assign ra_s       = OUT_ADDR[k*ADDR_W +: ADDR_W];
        assign zero_hit_s = HAS_ZERO & (ra_s == ZERO_IDX);

        // Read mux: zero during the sweep or for x0, then bypass, then storage.
        always_comb begin
            rd_data_s = {DATA_W{1'b0}};
            if (!run_s || zero_hit_s) begin
                rd_data_s = {DATA_W{1'b0}};
            end else if (wr_en_s && (INADDRESS == ra_s)) begin
                rd_data_s = IN;
            end else begin
                rd_data_s = mem_q[ra_s];
            end
        end

        assign OUT_DATA[k*DATA_W +: DATA_W] = rd_data_s;
        assign OUT_BUSY[k]                  = run_s & ~zero_hit_s & sb_busy_s[k];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed checks on the default configuration and a
// randomized run of a 4-port 64-bit 16-entry instance against a reference model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        a_reset, a_write, a_issue, a_ready;
    logic [31:0] a_in;
    logic [4:0]  a_waddr, a_iaddr;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_busy;

    reg_file_mp u_a (
        .CLK(clk), .RESET(a_reset), .IN(a_in), .INADDRESS(a_waddr), .WRITE(a_write),
        .ISSUE_EN(a_issue), .ISSUE_ADDR(a_iaddr), .OUT_ADDR(a_raddr),
        .OUT_DATA(a_rdata), .OUT_BUSY(a_busy), .READY(a_ready)
    );

    logic         b_reset, b_write, b_issue, b_ready;
    logic [63:0]  b_in;
    logic [3:0]   b_waddr, b_iaddr;
    logic [15:0]  b_raddr;
    logic [255:0] b_rdata;
    logic [3:0]   b_busy;

    reg_file_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG0(1)) u_b (
        .CLK(clk), .RESET(b_reset), .IN(b_in), .INADDRESS(b_waddr), .WRITE(b_write),
        .ISSUE_EN(b_issue), .ISSUE_ADDR(b_iaddr), .OUT_ADDR(b_raddr),
        .OUT_DATA(b_rdata), .OUT_BUSY(b_busy), .READY(b_ready)
    );

    // Reference model of the wide instance: contents, pending writes, sweep cycles left.
    logic [63:0] m_mem  [16];
    logic        m_busy [16];
    int          m_left;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [63:0] exp_d;
        logic        exp_b;

        a_reset = 1'b0; a_write = 1'b0; a_issue = 1'b0;
        a_in = 32'd0; a_waddr = 5'd0; a_iaddr = 5'd0; a_raddr = 10'd0;
        b_reset = 1'b0; b_write = 1'b0; b_issue = 1'b0;
        b_in = 64'd0; b_waddr = 4'd0; b_iaddr = 4'd0; b_raddr = 16'd0;
        m_left = 16;
        @(negedge clk);

        // Test 1: one reset cycle, READY low for 32 cycles, all reads zero.
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a_raddr = 10'($urandom);
            #1;
            chk("t1_ready_low", 64'(a_ready), 64'd0);
            chk("t1_rd0_zero", a_rdata, 64'd0);
            chk("t1_busy_zero", 64'(a_busy), 64'd0);
            tick();
        end
        #1;
        chk("t1_ready_high", 64'(a_ready), 64'd1);

        // Test 2: same-cycle bypass, then stored value.
        a_write = 1'b1; a_waddr = 5'd5; a_in = 32'hDEADBEEF; a_raddr = {5'd0, 5'd5};
        #1;
        chk("t2_bypass", 64'(a_rdata[31:0]), 64'h00000000DEADBEEF);
        tick();
        a_write = 1'b0;
        #1;
        chk("t2_stored", 64'(a_rdata[31:0]), 64'h00000000DEADBEEF);

        // Test 3: x0 ignores writes and issues.
        a_write = 1'b1; a_waddr = 5'd0; a_in = 32'h12345678;
        a_issue = 1'b1; a_iaddr = 5'd0; a_raddr = {5'd5, 5'd0};
        #1;
        chk("t3_x0_bypass", 64'(a_rdata[31:0]), 64'd0);
        chk("t3_x0_busy", 64'(a_busy[0]), 64'd0);
        tick();
        a_write = 1'b0; a_issue = 1'b0;
        #1;
        chk("t3_x0_after", 64'(a_rdata[31:0]), 64'd0);
        chk("t3_x0_busy_after", 64'(a_busy[0]), 64'd0);
        chk("t3_x5_kept", 64'(a_rdata[63:32]), 64'h00000000DEADBEEF);

        // Test 4: scoreboard set, hold, clear by writeback; set wins over clear.
        a_issue = 1'b1; a_iaddr = 5'd7; a_raddr = {5'd7, 5'd7};
        #1;
        chk("t4_busy_before", 64'(a_busy), 64'd0);
        tick();
        a_issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_busy_held", 64'(a_busy), 64'd3);
            tick();
        end
        a_write = 1'b1; a_waddr = 5'd7; a_in = 32'h55;
        #1;
        chk("t4_busy_wb", 64'(a_busy), 64'd0);
        chk("t4_data_wb", 64'(a_rdata[63:32]), 64'h55);
        tick();
        a_write = 1'b0;
        #1;
        chk("t4_busy_cleared", 64'(a_busy), 64'd0);
        a_issue = 1'b1; a_iaddr = 5'd7; a_write = 1'b1; a_waddr = 5'd7; a_in = 32'h66;
        tick();
        a_issue = 1'b0; a_write = 1'b0;
        #1;
        chk("t4_set_wins", 64'(a_busy), 64'd3);
        chk("t4_data_66", 64'(a_rdata[31:0]), 64'h66);

        // Test 5: reset at clear pointer 10 restarts the sweep; writes in the sweep dropped.
        a_write = 1'b1; a_waddr = 5'd3; a_in = 32'hABC;
        tick();
        a_write = 1'b0; a_raddr = {5'd7, 5'd3};
        #1;
        chk("t5_x3_written", 64'(a_rdata[31:0]), 64'hABC);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_write = 1'b1; a_waddr = 5'd3; a_in = 32'hFFFFFFFF;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("t5_ready_low", 64'(a_ready), 64'd0);
            chk("t5_rd_zero", a_rdata, 64'd0);
            tick();
        end
        a_write = 1'b0;
        #1;
        chk("t5_ready_high", 64'(a_ready), 64'd1);
        chk("t5_x3_zero", 64'(a_rdata[31:0]), 64'd0);
        chk("t5_busy_reset", 64'(a_busy), 64'd0);

        // Test 6: randomized wide instance against the model, including a mid-run reset.
        for (int c = 0; c < 10000; c++) begin
            b_reset = (c == 0) || (c == 6000);
            b_write = 1'($urandom_range(0, 1));
            b_waddr = 4'($urandom);
            b_in    = {$urandom, $urandom};
            b_issue = ($urandom_range(0, 3) == 0);
            b_iaddr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra = 4'($urandom);
                b_raddr = {ra, ra, ra, ra};
            end else begin
                b_raddr = 16'($urandom);
            end
            #1;
            if (c > 0) begin
                chk("t6_ready", 64'(b_ready), 64'(m_left == 0));
                for (int k = 0; k < 4; k++) begin
                    ra = b_raddr[k*4 +: 4];
                    if (m_left != 0 || ra == 4'd0)
                        exp_d = 64'd0;
                    else if (b_write && b_waddr == ra)
                        exp_d = b_in;
                    else
                        exp_d = m_mem[ra];
                    exp_b = (m_left == 0) && (ra != 4'd0) && m_busy[ra]
                            && !(b_write && b_waddr == ra);
                    chk("t6_data", b_rdata[k*64 +: 64], exp_d);
                    chk("t6_busy", 64'(b_busy[k]), 64'(exp_b));
                end
            end
            @(posedge clk);
            if (b_reset) begin
                for (int i = 0; i < 16; i++) begin
                    m_mem[i]  = 64'd0;
                    m_busy[i] = 1'b0;
                end
                m_left = 16;
            end else if (m_left != 0) begin
                m_left = m_left - 1;
            end else begin
                if (b_write && b_waddr != 4'd0) begin
                    m_mem[b_waddr]  = b_in;
                    m_busy[b_waddr] = 1'b0;
                end
                if (b_issue && b_iaddr != 4'd0) m_busy[b_iaddr] = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
